// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle plus the external SRAM pins of the memory controller.
// The slave modport is the controller; the master modport is the pipeline and SRAM side.
interface sram_mem_controller_if #(
   parameter int SRAM_AW = 18
);
   logic                MEMread;
   logic                MEMwrite;
   logic [31:0]         address;
   logic [31:0]         value;
   logic [31:0]         MEM_result;
   logic                ready;
   logic [SRAM_AW-1:0]  sram_addr;
   logic [15:0]         sram_dq_out;
   logic                sram_dq_oe;
   logic [15:0]         sram_dq_in;
   logic                sram_we_n;

   modport slave (
      input  MEMread, MEMwrite, address, value, sram_dq_in,
      output MEM_result, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport master (
      output MEMread, MEMwrite, address, value, sram_dq_in,
      input  MEM_result, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_mem_controller.sv
// Multi-cycle MEM-stage controller: each 32-bit access becomes two 16-bit SRAM accesses
// held for ACCESS_CYCLES cycles each, with ready low (pipeline frozen) until DONE.
module sram_mem_controller #(
   parameter int ACCESS_CYCLES = 2,
   parameter int BASE_ADDR     = 1024,
   parameter int SRAM_AW       = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_mem_controller_if.slave  bus
);

   localparam int WORD_W = SRAM_AW - 1;
   localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_opWrite;
   logic [WORD_W-1:0]   r_word;
   logic [31:0]         r_value;
   logic [31:0]         r_rdata;
   logic [SRAM_AW-1:0]  r_sramAddr;
   logic [15:0]         r_dqOut;
   logic                r_dqOe;
   logic                r_weN;

   logic                w_req;
   logic [WORD_W-1:0]   w_word;
   logic [CNT_W-1:0]    w_cntNext;
   logic                w_lastCnt;
   logic                w_weNext;

   // Word index wraps modulo the SRAM size; the top address bits are simply dropped.
   assign w_req     = bus.MEMread | bus.MEMwrite;
   assign w_word    = WORD_W'((bus.address - 32'(BASE_ADDR)) >> 2);
   assign w_cntNext = r_cnt + CNT_W'(1);
   assign w_lastCnt = (r_cnt == LAST_CNT);
   assign w_weNext  = ~(r_opWrite && (w_cntNext < LAST_CNT));

   // SRAM pins are registered alongside the state so they line up with the state they belong to;
   // the final cycle of each half releases we_n as write recovery.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_opWrite  <= 1'b0;
         r_word     <= '0;
         r_value    <= '0;
         r_rdata    <= '0;
         r_sramAddr <= '0;
         r_dqOut    <= '0;
         r_dqOe     <= 1'b0;
         r_weN      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_state    <= LOW;
                  r_cnt      <= '0;
                  r_opWrite  <= bus.MEMwrite;
                  r_word     <= w_word;
                  r_value    <= bus.value;
                  r_sramAddr <= {w_word, 1'b0};
                  r_dqOut    <= bus.MEMwrite ? bus.value[15:0] : 16'h0000;
                  r_dqOe     <= bus.MEMwrite;
                  r_weN      <= ~bus.MEMwrite;
               end
            end
            LOW: begin
               if (w_lastCnt) begin
                  if (!r_opWrite) begin
                     r_rdata[15:0] <= bus.sram_dq_in;
                  end
                  r_state    <= HIGH;
                  r_cnt      <= '0;
                  r_sramAddr <= {r_word, 1'b1};
                  r_dqOut    <= r_opWrite ? r_value[31:16] : 16'h0000;
                  r_dqOe     <= r_opWrite;
                  r_weN      <= ~r_opWrite;
               end else begin
                  r_cnt <= w_cntNext;
                  r_weN <= w_weNext;
               end
            end
            HIGH: begin
               if (w_lastCnt) begin
                  if (!r_opWrite) begin
                     r_rdata[31:16] <= bus.sram_dq_in;
                  end
                  r_state    <= DONE;
                  r_cnt      <= '0;
                  r_sramAddr <= '0;
                  r_dqOut    <= '0;
                  r_dqOe     <= 1'b0;
                  r_weN      <= 1'b1;
               end else begin
                  r_cnt <= w_cntNext;
                  r_weN <= w_weNext;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // In IDLE a pending request freezes the pipeline in the same cycle it appears.
   assign bus.ready       = (r_state == IDLE) ? ~w_req : (r_state == DONE);
   assign bus.MEM_result  = bus.MEMread ? r_rdata : 32'h0000_0000;
   assign bus.sram_addr   = r_sramAddr;
   assign bus.sram_dq_out = r_dqOut;
   assign bus.sram_dq_oe  = r_dqOe;
   assign bus.sram_we_n   = r_weN;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: behavioural async SRAM plus a word-level
// reference memory that predicts every bus cycle and every load result.
module tb_sram_mem_controller;

   localparam int AC   = 2;
   localparam int BASE = 1024;
   localparam int AW   = 18;
   localparam int N    = 2 * AC + 1;
   localparam int BW   = AW + 19;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   sram_mem_controller_if #(.SRAM_AW(AW)) busIf ();

   sram_mem_controller #(
      .ACCESS_CYCLES (AC),
      .BASE_ADDR     (BASE),
      .SRAM_AW       (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf.slave)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM: reads are combinational, writes land while we_n is low.
   logic [15:0] sramMem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (rst && !busIf.sram_we_n && busIf.sram_dq_oe) begin
         sramMem[busIf.sram_addr] <= busIf.sram_dq_out;
      end
   end
   assign busIf.sram_dq_in = sramMem[busIf.sram_addr];

   // Reference model: 32-bit words by SRAM word index, and the last fully loaded word.
   logic [31:0] refMem [int unsigned];
   logic [31:0] lastRdata;

   logic [BW-1:0] obsBus [0:N];
   logic [31:0]   obsResult;

   function automatic logic [BW-1:0] busNow();
      return {busIf.ready, busIf.sram_addr, busIf.sram_dq_out, busIf.sram_dq_oe, busIf.sram_we_n};
   endfunction

   function automatic int unsigned wordOf(input logic [31:0] addr);
      logic [31:0] d;
      d = addr - 32'(BASE);
      return (d >> 2) % 32'(1 << (AW - 1));
   endfunction

   // Expected bus in cycle k of an access (cycle 0 = request seen in IDLE, cycle N = DONE).
   function automatic logic [BW-1:0] expBus(input int k, input bit isWrite,
                                            input int unsigned word, input logic [31:0] val);
      logic          rdy;
      logic [AW-1:0] a;
      logic [15:0]   dq;
      logic          oe;
      logic          we;
      int            half;
      int            c;
      rdy = (k == N);
      a   = '0;
      dq  = '0;
      oe  = 1'b0;
      we  = 1'b1;
      if (k >= 1 && k <= 2 * AC) begin
         half = (k - 1) / AC;
         c    = (k - 1) % AC;
         a    = AW'(2 * word + half);
         if (isWrite) begin
            dq = (half == 1) ? val[31:16] : val[15:0];
            oe = 1'b1;
            we = (c < AC - 1) ? 1'b0 : 1'b1;
         end
      end
      return {rdy, a, dq, oe, we};
   endfunction

   // Data-out during a read access is unconstrained, so it is excluded there.
   function automatic logic [BW-1:0] busMask(input int k, input bit isWrite);
      logic [BW-1:0] m;
      m = '1;
      if (!isWrite && k >= 1 && k <= 2 * AC) m[17:2] = '0;
      return m;
   endfunction

   task automatic modelAccess(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] val);
      int unsigned w;
      w = wordOf(addr);
      if (wr) refMem[w] = val;
      else if (rd) lastRdata = refMem.exists(w) ? refMem[w] : 32'hxxxx_xxxx;
   endtask

   // Presents one request just after an edge leading into IDLE and records cycles 0..N.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] val);
      @(posedge clk);
      #1;
      busIf.MEMread  = rd;
      busIf.MEMwrite = wr;
      busIf.address  = addr;
      busIf.value    = val;
      #1;
      obsBus[0] = busNow();
      for (int k = 1; k <= N; k++) begin
         @(posedge clk);
         #2;
         obsBus[k] = busNow();
      end
      obsResult = busIf.MEM_result;
   endtask

   task automatic goIdle();
      @(posedge clk);
      #1;
      busIf.MEMread  = 1'b0;
      busIf.MEMwrite = 1'b0;
      busIf.address  = '0;
      busIf.value    = '0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      busIf.MEMread  = 1'b0;
      busIf.MEMwrite = 1'b0;
      busIf.address  = '0;
      busIf.value    = '0;
      lastRdata      = '0;
      #2 rst = 1'b0;
      #2;
      checks++;
      if (busNow() !== {1'b1, AW'(0), 16'h0000, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_bus: got %h expected %h", busNow(), {1'b1, AW'(0), 16'h0000, 1'b0, 1'b1});
      end
      checks++;
      if (busIf.MEM_result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_result: got %h expected 00000000", busIf.MEM_result);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         checks++;
         if (busNow() !== {1'b1, AW'(0), 16'h0000, 1'b0, 1'b1} || busIf.MEM_result !== 32'h0) begin
            errors++;
            $display("[TB] FAIL idle cycle %0d: got bus %h result %h expected bus %h result 0",
                     i, busNow(), busIf.MEM_result, {1'b1, AW'(0), 16'h0000, 1'b0, 1'b1});
         end
      end
   endtask

   task automatic test_write_readback();
      logic [31:0] expRes;
      applyStimulus(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
      modelAccess(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
      for (int k = 0; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b1)) !== (expBus(k, 1'b1, 0, 32'hDEAD_BEEF) & busMask(k, 1'b1))) begin
            errors++;
            $display("[TB] FAIL write_bus cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b1, 0, 32'hDEAD_BEEF));
         end
      end
      checks++;
      if (obsResult !== 32'h0) begin
         errors++;
         $display("[TB] FAIL write_result: got %h expected 00000000", obsResult);
      end
      goIdle();
      applyStimulus(1'b1, 1'b0, 32'd1024, $urandom);
      modelAccess(1'b1, 1'b0, 32'd1024, 32'h0);
      for (int k = 0; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b0)) !== (expBus(k, 1'b0, 0, 32'h0) & busMask(k, 1'b0))) begin
            errors++;
            $display("[TB] FAIL read_bus cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b0, 0, 32'h0));
         end
      end
      expRes = 32'hDEAD_BEEF;
      checks++;
      if (obsResult !== expRes || lastRdata !== expRes) begin
         errors++;
         $display("[TB] FAIL read_result: got %h expected %h", obsResult, expRes);
      end
      goIdle();
   endtask

   task automatic test_mapping_wrap();
      logic [31:0] addrs [2];
      logic [31:0] vals  [2];
      addrs[0] = 32'd1028;
      addrs[1] = 32'd1020;
      for (int i = 0; i < 2; i++) begin
         vals[i] = $urandom;
         applyStimulus(1'b0, 1'b1, addrs[i], vals[i]);
         modelAccess(1'b0, 1'b1, addrs[i], vals[i]);
         for (int k = 0; k <= N; k++) begin
            checks++;
            if ((obsBus[k] & busMask(k, 1'b1)) !== (expBus(k, 1'b1, wordOf(addrs[i]), vals[i]) & busMask(k, 1'b1))) begin
               errors++;
               $display("[TB] FAIL map_write addr %h cycle %0d: got %h expected %h", addrs[i], k, obsBus[k],
                        expBus(k, 1'b1, wordOf(addrs[i]), vals[i]));
            end
         end
         goIdle();
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, addrs[i], 32'h0);
         modelAccess(1'b1, 1'b0, addrs[i], 32'h0);
         checks++;
         if (obsBus[1][BW-2:18] !== AW'(2 * wordOf(addrs[i])) || obsBus[3][BW-2:18] !== AW'(2 * wordOf(addrs[i]) + 1)) begin
            errors++;
            $display("[TB] FAIL map_addr addr %h: got %h/%h expected %h/%h", addrs[i], obsBus[1][BW-2:18],
                     obsBus[3][BW-2:18], AW'(2 * wordOf(addrs[i])), AW'(2 * wordOf(addrs[i]) + 1));
         end
         checks++;
         if (obsResult !== vals[i]) begin
            errors++;
            $display("[TB] FAIL map_read addr %h: got %h expected %h", addrs[i], obsResult, vals[i]);
         end
         goIdle();
      end
   endtask

   task automatic test_both_asserted();
      logic [31:0] expRes;
      applyStimulus(1'b1, 1'b1, 32'd1032, 32'h1234_5678);
      modelAccess(1'b1, 1'b1, 32'd1032, 32'h1234_5678);
      for (int k = 0; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b1)) !== (expBus(k, 1'b1, 2, 32'h1234_5678) & busMask(k, 1'b1))) begin
            errors++;
            $display("[TB] FAIL both_bus cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b1, 2, 32'h1234_5678));
         end
      end
      expRes = lastRdata;
      checks++;
      if (obsResult !== expRes) begin
         errors++;
         $display("[TB] FAIL both_result: got %h expected %h", obsResult, expRes);
      end
      goIdle();
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
      modelAccess(1'b1, 1'b0, 32'd1032, 32'h0);
      checks++;
      if (obsResult !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL both_readback: got %h expected 12345678", obsResult);
      end
      goIdle();
   endtask

   task automatic test_reset_mid_read();
      int unsigned w;
      logic [BW-1:0] expIdle;
      w = wordOf(32'd1024);
      @(posedge clk);
      #1;
      busIf.MEMread  = 1'b1;
      busIf.MEMwrite = 1'b0;
      busIf.address  = 32'd1024;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (busIf.sram_addr !== AW'(2 * w + 1)) begin
         errors++;
         $display("[TB] FAIL midread_high_addr: got %h expected %h", busIf.sram_addr, AW'(2 * w + 1));
      end
      rst = 1'b0;
      lastRdata = '0;
      #1;
      expIdle = {1'b0, AW'(0), 16'h0000, 1'b0, 1'b1};
      checks++;
      if (busNow() !== expIdle || busIf.MEM_result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midread_async_reset: got bus %h result %h expected bus %h result 0",
                  busNow(), busIf.MEM_result, expIdle);
      end
      #2 rst = 1'b1;
      for (int k = 1; k <= N; k++) begin
         @(posedge clk);
         #2;
         obsBus[k] = busNow();
      end
      obsResult = busIf.MEM_result;
      modelAccess(1'b1, 1'b0, 32'd1024, 32'h0);
      for (int k = 1; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b0)) !== (expBus(k, 1'b0, w, 32'h0) & busMask(k, 1'b0))) begin
            errors++;
            $display("[TB] FAIL midread_restart cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b0, w, 32'h0));
         end
      end
      checks++;
      if (obsResult !== lastRdata) begin
         errors++;
         $display("[TB] FAIL midread_result: got %h expected %h", obsResult, lastRdata);
      end
      goIdle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      int unsigned w;
      v = $urandom;
      w = wordOf(32'd1036);
      applyStimulus(1'b0, 1'b1, 32'd1036, v);
      modelAccess(1'b0, 1'b1, 32'd1036, v);
      for (int k = 0; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b1)) !== (expBus(k, 1'b1, w, v) & busMask(k, 1'b1))) begin
            errors++;
            $display("[TB] FAIL b2b_write cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b1, w, v));
         end
      end
      applyStimulus(1'b1, 1'b0, 32'd1036, 32'h0);
      modelAccess(1'b1, 1'b0, 32'd1036, 32'h0);
      for (int k = 0; k <= N; k++) begin
         checks++;
         if ((obsBus[k] & busMask(k, 1'b0)) !== (expBus(k, 1'b0, w, 32'h0) & busMask(k, 1'b0))) begin
            errors++;
            $display("[TB] FAIL b2b_read cycle %0d: got %h expected %h", k, obsBus[k], expBus(k, 1'b0, w, 32'h0));
         end
      end
      checks++;
      if (obsResult !== v) begin
         errors++;
         $display("[TB] FAIL b2b_result: got %h expected %h", obsResult, v);
      end
      goIdle();
   endtask

   task automatic test_random();
      int          writtenQ [$];
      int          idx;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] val;
      logic [31:0] expRes;
      for (int it = 0; it < 24; it++) begin
         if (writtenQ.size() > 0 && $urandom_range(0, 1) == 1) begin
            idx = writtenQ[$urandom_range(0, writtenQ.size() - 1)];
            rd  = 1'b1;
            wr  = 1'b0;
         end else begin
            idx = $urandom_range(0, 7);
            rd  = ($urandom_range(0, 3) == 0);
            wr  = 1'b1;
            writtenQ.push_back(idx);
         end
         addr = 32'(BASE + 4 * idx) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) addr = addr + 32'(1 << (AW + 1));
         val = $urandom;
         applyStimulus(rd, wr, addr, val);
         modelAccess(rd, wr, addr, val);
         for (int k = 0; k <= N; k++) begin
            checks++;
            if ((obsBus[k] & busMask(k, wr)) !== (expBus(k, wr, wordOf(addr), val) & busMask(k, wr))) begin
               errors++;
               $display("[TB] FAIL rand_bus iter %0d addr %h cycle %0d: got %h expected %h", it, addr, k,
                        obsBus[k], expBus(k, wr, wordOf(addr), val));
            end
         end
         expRes = rd ? lastRdata : 32'h0;
         checks++;
         if (obsResult !== expRes) begin
            errors++;
            $display("[TB] FAIL rand_result iter %0d addr %h: got %h expected %h", it, addr, obsResult, expRes);
         end
         if ($urandom_range(0, 1) == 1) goIdle();
      end
      goIdle();
   endtask

   initial begin
      test_reset();
      test_idle();
      test_write_readback();
      test_mapping_wrap();
      test_both_asserted();
      test_reset_mid_read();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle memory-stage controller that replaces the single-cycle data array behind the MEM stage.
- Takes the MEM stage request (MEMread/MEMwrite, 32-bit address, 32-bit value) and runs each 32-bit access as two 16-bit accesses on an external asynchronous SRAM.
- Returns the read word on MEM_result.
- Drives ready; the pipeline freezes all stage registers while ready is low.

Parameters:
- ACCESS_CYCLES, 2: cycles each 16-bit half-access is held on the SRAM bus; legal minimum 2.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM address width in 16-bit halfwords.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- MEMread  input  1  load request from the MEM stage.
- MEMwrite  input  1  store request from the MEM stage.
- address  input  32  byte address from the ALU result.
- value  input  32  store data.
- MEM_result  output  32  load data to MEM/WB.
- ready  output  1  high = the MEM stage may advance; low = freeze pipeline.
- sram_addr  output  SRAM_AW  halfword address to the SRAM.
- sram_dq_out  output  16  write data to the SRAM.
- sram_dq_oe  output  1  high = controller drives the data bus.
- sram_dq_in  input  16  read data from the SRAM.
- sram_we_n  output  1  active-low SRAM write enable.

Behaviour:
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, computed modulo 2^32.
  - Low half: sram_addr = {word[SRAM_AW-2:0], 1'b0}. High half: sram_addr = {word[SRAM_AW-2:0], 1'b1}.
  - Upper word bits are discarded, so addresses wrap silently.
- Request:
  - req = MEMread | MEMwrite.
  - If both are high, the access is a write; MEM_result is still driven as below.
- States: IDLE, LOW, HIGH, DONE. A cycle counter cnt runs 0..ACCESS_CYCLES-1 inside LOW and HIGH.
- IDLE:
  - ready = ~req.
  - On a clock edge with req=1: latch op, word and value; cnt=0; go to LOW.
- LOW:
  - sram_addr = low-half address.
  - Write: sram_dq_out = value[15:0], sram_dq_oe=1, sram_we_n=0 when cnt < ACCESS_CYCLES-1, else sram_we_n=1 (write recovery cycle).
  - Read: sram_dq_oe=0, sram_we_n=1.
  - On the edge where cnt = ACCESS_CYCLES-1: a read captures sram_dq_in into rdata[15:0]; cnt=0; go to HIGH.
- HIGH:
  - Same as LOW using the high-half address and value[31:16].
  - A read captures sram_dq_in into rdata[31:16] on the last edge.
  - Then go to DONE.
- DONE:
  - ready=1 for exactly one cycle; next state is IDLE unconditionally.
  - The pipeline advances on this edge.
  - A new request presented by the next instruction is seen in IDLE the following cycle.
- Latency:
  - Request first seen in cycle 0 (IDLE); ready is high in cycle 2*ACCESS_CYCLES+1.
  - With the default: cycle 5, i.e. 5 freeze cycles.
- Outputs:
  - MEM_result = MEMread ? rdata : 32'b0 (combinational mux on the registered rdata).
  - rdata is stable and fully assembled in DONE.
  - In IDLE and DONE: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Request and address inputs are ignored outside IDLE; the latched copies are used throughout LOW, HIGH and DONE.
- Reset (rst=0), asynchronous, at any time including mid-access:
  - state=IDLE, cnt=0, rdata=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - A partially written word is left as-is in the SRAM.
- SRAM contents are outside this block; no initialisation is performed.

Test Plan:
- Write with ACCESS_CYCLES=2: MEMwrite=1, address=1024, value=0xDEADBEEF.
  - Required: sram_addr=0 with dq_out=0xBEEF for 2 cycles, then sram_addr=1 with dq_out=0xDEAD for 2 cycles.
  - sram_we_n low in the first cycle of each half only; ready=0 in cycles 0-4 and 1 in cycle 5.
- Read-back from a behavioural SRAM model: MEMread=1, address=1024.
  - Required: MEM_result=0xDEADBEEF with ready=1 in cycle 5; sram_dq_oe=0 throughout.
- Mapping and wrap: MEMwrite at address=1028 gives sram_addr 2 then 3.
  - address=1020 (word 0x3FFFFFFF) gives sram_addr 0x3FFFE then 0x3FFFF.
- Idle and both-asserted:
  - No request: ready=1, sram_we_n=1, MEM_result=0.
  - MEMread=MEMwrite=1 with value=0x12345678: a write sequence occurs, and MEM_result in DONE reflects rdata.
- Reset mid-read: assert rst=0 during HIGH.
  - Required: outputs return to reset values immediately, without waiting for a clock edge.
  - After release with MEMread held: a full 5-cycle read restarts from LOW.
- Back-to-back: write then read of the same address on consecutive instructions.
  - Required: two 5-cycle freezes separated by one ready cycle; the read returns the written word.
